// File: rtl/pu_or1k_pfpu64_addsub_rnd_if.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : pu_or1k_pfpu64_addsub_rnd_if
// Purpose  : Bundle from the add/sub front-end into the rounding back-end.
// Revision : 1.0  initial release
// =============================================================================
interface pu_or1k_pfpu64_addsub_rnd_if;
    logic        add_rdy_i;
    logic        add_sign_i;
    logic        add_sub_0_i;
    logic [4:0]  add_shl_i;
    logic [9:0]  add_exp10shl_i;
    logic [9:0]  add_exp10sh0_i;
    logic [27:0] add_fract28_i;
    logic        add_inv_i;
    logic        add_inf_i;
    logic        add_snan_i;
    logic        add_qnan_i;
    logic        add_anan_sign_i;
    logic        rdy_o;
    logic [31:0] result_o;
    logic        ine_o;
    logic        ovf_o;
    logic        unf_o;
    logic        inv_o;
    logic        zero_o;

    modport master (
        output add_rdy_i, add_sign_i, add_sub_0_i, add_shl_i, add_exp10shl_i,
               add_exp10sh0_i, add_fract28_i, add_inv_i, add_inf_i, add_snan_i,
               add_qnan_i, add_anan_sign_i,
        input  rdy_o, result_o, ine_o, ovf_o, unf_o, inv_o, zero_o
    );

    modport slave (
        input  add_rdy_i, add_sign_i, add_sub_0_i, add_shl_i, add_exp10shl_i,
               add_exp10sh0_i, add_fract28_i, add_inv_i, add_inf_i, add_snan_i,
               add_qnan_i, add_anan_sign_i,
        output rdy_o, result_o, ine_o, ovf_o, unf_o, inv_o, zero_o
    );
endinterface
`default_nettype wire

// File: rtl/pu_or1k_pfpu64_addsub_rnd.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : pu_or1k_pfpu64_addsub_rnd
// Purpose  : Two-stage normalize / IEEE-754 binary32 round / pack back-end.
// Revision : 1.0  initial release
// =============================================================================
module pu_or1k_pfpu64_addsub_rnd (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_i,
    input  logic                              adv_i,
    input  logic [1:0]                        rmode_i,
    pu_or1k_pfpu64_addsub_rnd_if.slave        ifc
);
    localparam logic [1:0]  c_RM_RNE = 2'b00;
    localparam logic [1:0]  c_RM_RTZ = 2'b01;
    localparam logic [1:0]  c_RM_RUP = 2'b10;
    localparam logic [30:0] c_INF    = 31'h7F800000;
    localparam logic [30:0] c_MAX    = 31'h7F7FFFFF;

    // ---------------- stage 1: final alignment ----------------
    logic [26:0] w_s1_fract;
    logic [9:0]  w_s1_exp;

    always_comb begin
        w_s1_fract = ifc.add_fract28_i[26:0];
        w_s1_exp   = ifc.add_exp10sh0_i;
        if (ifc.add_fract28_i[27]) begin
            w_s1_fract = {ifc.add_fract28_i[27:2], |ifc.add_fract28_i[1:0]};
            w_s1_exp   = ifc.add_exp10sh0_i + 10'd1;
        end else if (ifc.add_shl_i != 5'd0) begin
            w_s1_fract = 27'(ifc.add_fract28_i << ifc.add_shl_i);
            w_s1_exp   = ifc.add_exp10shl_i;
        end
    end

    logic        r_s1_rdy, r_s1_sign, r_s1_sub0, r_s1_fz;
    logic        r_s1_inv, r_s1_inf, r_s1_snan, r_s1_qnan, r_s1_anan;
    logic [1:0]  r_s1_rmode;
    logic [26:0] r_s1_fract;
    logic [9:0]  r_s1_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_rdy   <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_sub0  <= 1'b0;
            r_s1_fz    <= 1'b0;
            r_s1_inv   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_snan  <= 1'b0;
            r_s1_qnan  <= 1'b0;
            r_s1_anan  <= 1'b0;
            r_s1_rmode <= 2'b00;
            r_s1_fract <= '0;
            r_s1_exp   <= '0;
        end else begin
            if (flush_i)
                r_s1_rdy <= 1'b0;
            else if (adv_i)
                r_s1_rdy <= ifc.add_rdy_i;
            if (adv_i) begin
                r_s1_sign  <= ifc.add_sign_i;
                r_s1_sub0  <= ifc.add_sub_0_i;
                r_s1_fz    <= (ifc.add_fract28_i == 28'd0);
                r_s1_inv   <= ifc.add_inv_i;
                r_s1_inf   <= ifc.add_inf_i;
                r_s1_snan  <= ifc.add_snan_i;
                r_s1_qnan  <= ifc.add_qnan_i;
                r_s1_anan  <= ifc.add_anan_sign_i;
                r_s1_rmode <= rmode_i;
                r_s1_fract <= w_s1_fract;
                r_s1_exp   <= w_s1_exp;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic        w_lsb, w_g, w_rs, w_inexact, w_up, w_tiny, w_ovf_n;
    logic [24:0] w_m25;
    logic [9:0]  w_exp_rnd;
    logic [22:0] w_mant;
    logic [31:0] w_res;
    logic        w_ine, w_ovf, w_unf, w_inv;

    assign w_lsb     = r_s1_fract[3];
    assign w_g       = r_s1_fract[2];
    assign w_rs      = |r_s1_fract[1:0];
    assign w_inexact = w_g | w_rs;
    assign w_tiny    = ~r_s1_fract[26];

    always_comb begin
        case (r_s1_rmode)
            c_RM_RNE: w_up = w_g & (w_rs | w_lsb);
            c_RM_RTZ: w_up = 1'b0;
            c_RM_RUP: w_up = w_inexact & ~r_s1_sign;
            default:  w_up = w_inexact & r_s1_sign;
        endcase
    end

    assign w_m25 = {1'b0, r_s1_fract[26:3]} + {24'd0, w_up};

    // A denormal that rounds into the hidden bit becomes the smallest normal.
    always_comb begin
        w_exp_rnd = 10'd0;
        w_mant    = w_m25[22:0];
        if (w_m25[24]) begin
            w_exp_rnd = r_s1_exp + 10'd1;
            w_mant    = 23'd0;
        end else if (w_m25[23]) begin
            w_exp_rnd = (r_s1_exp == 10'd0) ? 10'd1 : r_s1_exp;
        end
    end

    assign w_ovf_n = (w_exp_rnd >= 10'd255);

    always_comb begin
        w_res = {r_s1_sign, w_exp_rnd[7:0], w_mant};
        w_ine = w_inexact | w_ovf_n;
        w_ovf = w_ovf_n;
        w_unf = w_tiny & w_inexact;
        w_inv = 1'b0;
        if (w_ovf_n) begin
            case (r_s1_rmode)
                c_RM_RNE: w_res = {r_s1_sign, c_INF};
                c_RM_RTZ: w_res = {r_s1_sign, c_MAX};
                c_RM_RUP: w_res = r_s1_sign ? {1'b1, c_MAX} : {1'b0, c_INF};
                default:  w_res = r_s1_sign ? {1'b1, c_INF} : {1'b0, c_MAX};
            endcase
        end
        if (r_s1_snan | r_s1_qnan | r_s1_inv | r_s1_inf | r_s1_sub0 | r_s1_fz) begin
            w_ine = 1'b0;
            w_ovf = 1'b0;
            w_unf = 1'b0;
            if (r_s1_snan | r_s1_qnan) begin
                w_res = {r_s1_anan, 8'hFF, 1'b1, 22'd0};
                w_inv = r_s1_snan;
            end else if (r_s1_inv) begin
                w_res = 32'h7FC00000;
                w_inv = 1'b1;
            end else if (r_s1_inf) begin
                w_res = {r_s1_sign, 8'hFF, 23'd0};
            end else if (r_s1_sub0) begin
                w_res = (r_s1_rmode == 2'b11) ? 32'h80000000 : 32'h00000000;
            end else begin
                w_res = {r_s1_sign, 31'd0};
            end
        end
    end

    logic        r_rdy, r_ine, r_ovf, r_unf, r_inv, r_zero;
    logic [31:0] r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy    <= 1'b0;
            r_result <= '0;
            r_ine    <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inv    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            if (flush_i)
                r_rdy <= 1'b0;
            else if (adv_i)
                r_rdy <= r_s1_rdy;
            if (adv_i) begin
                r_result <= w_res;
                r_ine    <= w_ine;
                r_ovf    <= w_ovf;
                r_unf    <= w_unf;
                r_inv    <= w_inv;
                r_zero   <= (w_res[30:0] == 31'd0);
            end
        end
    end

    assign ifc.rdy_o    = r_rdy;
    assign ifc.result_o = r_result;
    assign ifc.ine_o    = r_ine;
    assign ifc.ovf_o    = r_ovf;
    assign ifc.unf_o    = r_unf;
    assign ifc.inv_o    = r_inv;
    assign ifc.zero_o   = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_pu_or1k_pfpu64_addsub_rnd.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_pu_or1k_pfpu64_addsub_rnd
// Purpose  : Scoreboard bench for the binary32 add/sub round/pack back-end.
// Revision : 1.0  initial release
// =============================================================================
module tb_pu_or1k_pfpu64_addsub_rnd;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush_i;
    logic       adv_i;
    logic [1:0] rmode_i;

    pu_or1k_pfpu64_addsub_rnd_if ifc ();

    pu_or1k_pfpu64_addsub_rnd dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .adv_i   (adv_i),
        .rmode_i (rmode_i),
        .ifc     (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sign, sub0;
        logic [4:0]  shl;
        logic [9:0]  e_shl, e_sh0;
        logic [27:0] fract;
        logic        inv, inf, snan, qnan, anan;
        logic [1:0]  rm;
    } stim_t;

    typedef struct packed {
        logic [31:0] res;
        logic        ine, ovf, unf, inv, zero;
    } resp_t;

    resp_t sb_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // Reference: real-valued view of the fraction as integer mantissa + remainder.
    function automatic resp_t model(stim_t s);
        longint fr, f, mant, rem, m, mf;
        int     e, ef;
        bit     g, rs, lsb, inexact, up, tiny, ovf;
        logic [31:0] res;
        resp_t  r;
        fr = longint'(s.fract);
        if (fr >= 134217728) begin
            f = (fr / 4) * 2 + (((fr % 4) != 0) ? 1 : 0);
            e = int'(s.e_sh0) + 1;
        end else if (s.shl != 0) begin
            f = (fr * (longint'(1) << s.shl)) % 268435456;
            e = int'(s.e_shl);
        end else begin
            f = fr;
            e = int'(s.e_sh0);
        end
        mant    = (f / 8) % 16777216;
        rem     = f % 8;
        lsb     = (mant % 2) != 0;
        g       = rem >= 4;
        rs      = (rem % 4) != 0;
        inexact = rem != 0;
        tiny    = mant < 8388608;
        case (s.rm)
            2'd0:    up = g && (rs || lsb);
            2'd1:    up = 1'b0;
            2'd2:    up = inexact && !s.sign;
            default: up = inexact && s.sign;
        endcase
        m = mant + (up ? 1 : 0);
        if (m == 16777216) begin
            ef = e + 1;  mf = 0;
        end else if (m >= 8388608) begin
            ef = (e == 0) ? 1 : e;  mf = m - 8388608;
        end else begin
            ef = 0;  mf = m;
        end
        ovf = ef >= 255;
        res = {s.sign, 8'(ef), 23'(mf)};
        if (ovf) begin
            case (s.rm)
                2'd0:    res = {s.sign, 31'h7F800000};
                2'd1:    res = {s.sign, 31'h7F7FFFFF};
                2'd2:    res = s.sign ? 32'hFF7FFFFF : 32'h7F800000;
                default: res = s.sign ? 32'hFF800000 : 32'h7F7FFFFF;
            endcase
        end
        r.ine = inexact || ovf;
        r.ovf = ovf;
        r.unf = tiny && inexact;
        r.inv = 1'b0;
        if (s.snan || s.qnan || s.inv || s.inf || s.sub0 || fr == 0) begin
            r.ine = 0; r.ovf = 0; r.unf = 0;
            if (s.snan || s.qnan) begin
                res = {s.anan, 8'hFF, 1'b1, 22'd0};  r.inv = s.snan;
            end else if (s.inv) begin
                res = 32'h7FC00000;  r.inv = 1'b1;
            end else if (s.inf)
                res = {s.sign, 8'hFF, 23'd0};
            else if (s.sub0)
                res = (s.rm == 2'd3) ? 32'h80000000 : 32'h00000000;
            else
                res = {s.sign, 31'd0};
        end
        r.res  = res;
        r.zero = (res[30:0] == 31'd0);
        return r;
    endfunction

    function automatic stim_t mk(logic [27:0] fract, logic [9:0] e0, logic [4:0] shl,
                                 logic [9:0] eshl, logic [1:0] rm, logic sign);
        stim_t s;
        s = '0;
        s.fract = fract; s.e_sh0 = e0; s.shl = shl; s.e_shl = eshl; s.rm = rm; s.sign = sign;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int k, v, sh;
        logic [27:0] r28, msk;
        s = '0;
        s.rm   = 2'($urandom);
        s.sign = 1'($urandom);
        s.anan = 1'($urandom);
        s.e_sh0 = (($urandom % 4) == 0) ? 10'($urandom_range(250, 254)) : 10'($urandom_range(0, 300));
        s.e_shl = 10'($urandom_range(0, 300));
        r28 = 28'($urandom);
        k = $urandom_range(0, 19);
        case (k)
            0: begin
                s.snan = 1'($urandom); s.qnan = ~s.snan | 1'($urandom);
                s.inv = 1'($urandom); s.inf = 1'($urandom); s.fract = r28;
            end
            1: begin s.inv = 1'b1; s.inf = 1'($urandom); s.fract = r28; end
            2: begin s.inf = 1'b1; s.fract = r28; end
            3: s.sub0 = 1'b1;
            4: s.fract = 28'd0;
            default: begin
                v = $urandom_range(0, 3);
                if (v == 0)
                    s.fract = {1'b1, r28[26:0]};
                else if (v == 1) begin
                    s.fract = {2'b01, r28[25:0]};
                    if (($urandom % 6) == 0) s.fract[26:3] = '1;
                end else if (v == 2) begin
                    sh = $urandom_range(1, 26);
                    s.shl = 5'(sh);
                    msk = (28'd1 << (26 - sh)) - 28'd1;
                    s.fract = (28'd1 << (26 - sh)) | (r28 & msk);
                end else begin
                    s.fract = {2'b00, r28[25:0]};
                    s.e_sh0 = 10'd1;
                end
            end
        endcase
        return s;
    endfunction

    task automatic drive(stim_t s, bit valid, bit push);
        ifc.add_rdy_i       = valid;
        ifc.add_sign_i      = s.sign;
        ifc.add_sub_0_i     = s.sub0;
        ifc.add_shl_i       = s.shl;
        ifc.add_exp10shl_i  = s.e_shl;
        ifc.add_exp10sh0_i  = s.e_sh0;
        ifc.add_fract28_i   = s.fract;
        ifc.add_inv_i       = s.inv;
        ifc.add_inf_i       = s.inf;
        ifc.add_snan_i      = s.snan;
        ifc.add_qnan_i      = s.qnan;
        ifc.add_anan_sign_i = s.anan;
        rmode_i             = s.rm;
        if (valid && push && adv_i) sb_q.push_back(model(s));
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic resp_t dut_resp();
        return {ifc.result_o, ifc.ine_o, ifc.ovf_o, ifc.unf_o, ifc.inv_o, ifc.zero_o};
    endfunction

    // Monitor: a new result exists when the output stage advanced with rdy_o set.
    initial begin
        bit    adv_e;
        resp_t act, req;
        forever begin
            @(posedge clk);
            adv_e = adv_i;
            @(negedge clk);
            if (adv_e && ifc.rdy_o) begin
                act = dut_resp();
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, required no output", act);
                end else begin
                    req = sb_q.pop_front();
                    if (act !== req) begin
                        n_fail++;
                        $display("FAIL result: got res=%h ine/ovf/unf/inv/zero=%b%b%b%b%b, required res=%h ine/ovf/unf/inv/zero=%b%b%b%b%b",
                                 act.res, act.ine, act.ovf, act.unf, act.inv, act.zero,
                                 req.res, req.ine, req.ovf, req.unf, req.inv, req.zero);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish within 200us");
        $fatal(1);
    end

    initial begin
        stim_t d0, s, dir[$];
        logic [31:0] held;
        d0 = mk(28'h8000000, 10'd127, 5'd0, 10'd0, 2'd0, 1'b0);
        dir.push_back(mk(28'h4000004, 10'd127, 5'd0, 10'd0, 2'd0, 1'b0));
        dir.push_back(mk(28'h4000004, 10'd127, 5'd0, 10'd0, 2'd2, 1'b0));
        dir.push_back(mk(28'h8000000, 10'd254, 5'd0, 10'd0, 2'd0, 1'b0));
        dir.push_back(mk(28'h8000000, 10'd254, 5'd0, 10'd0, 2'd1, 1'b0));
        dir.push_back(mk(28'h8000000, 10'd254, 5'd0, 10'd0, 2'd2, 1'b1));
        dir.push_back(mk(28'h8000000, 10'd254, 5'd0, 10'd0, 2'd3, 1'b0));
        dir.push_back(mk(28'h0800000, 10'd0, 5'd3, 10'd124, 2'd0, 1'b0));
        dir.push_back(mk(28'h2000000, 10'd1, 5'd0, 10'd0, 2'd0, 1'b0));
        dir.push_back(mk(28'h3FFFFFC, 10'd1, 5'd0, 10'd0, 2'd0, 1'b0));
        s = mk(28'h4000000, 10'd127, 5'd0, 10'd0, 2'd0, 1'b1); s.snan = 1'b1; dir.push_back(s);
        s = mk(28'h4000000, 10'd127, 5'd0, 10'd0, 2'd3, 1'b0); s.inv = 1'b1; dir.push_back(s);
        s = mk(28'h4000000, 10'd127, 5'd0, 10'd0, 2'd0, 1'b1); s.inf = 1'b1; dir.push_back(s);
        s = mk(28'h0, 10'd127, 5'd0, 10'd0, 2'd3, 1'b0); s.sub0 = 1'b1; dir.push_back(s);
        s = mk(28'h0, 10'd127, 5'd0, 10'd0, 2'd0, 1'b1); s.sub0 = 1'b1; dir.push_back(s);
        dir.push_back(mk(28'h0, 10'd127, 5'd0, 10'd0, 2'd2, 1'b1));

        rst = 1'b1; flush_i = 1'b0; adv_i = 1'b0;
        drive('0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_rdy", 64'(ifc.rdy_o), 64'd0);
        chk("reset_outputs", 64'(dut_resp()), 64'd0);
        rst = 1'b0;

        @(negedge clk);
        adv_i = 1'b1;
        drive(d0, 1'b1, 1'b1);
        @(negedge clk);
        drive(d0, 1'b0, 1'b0);
        chk("latency_1cyc_rdy", 64'(ifc.rdy_o), 64'd0);
        @(negedge clk);
        chk("latency_2cyc_rdy", 64'(ifc.rdy_o), 64'd1);

        foreach (dir[i]) begin
            drive(dir[i], 1'b1, 1'b1);
            @(negedge clk);
        end

        for (int i = 0; i < 400; i++) begin
            adv_i = (($urandom % 4) != 0);
            drive(rand_stim(), (($urandom % 5) != 0), 1'b1);
            @(negedge clk);
        end

        adv_i = 1'b1;
        drive(d0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("drain_queue_empty", 64'(sb_q.size()), 64'd0);

        drive(dir[0], 1'b1, 1'b1);
        @(negedge clk);
        drive(dir[0], 1'b0, 1'b0);
        @(negedge clk);
        adv_i = 1'b0;
        held  = ifc.result_o;
        repeat (3) begin
            @(negedge clk);
            chk("hold_rdy", 64'(ifc.rdy_o), 64'd1);
            chk("hold_result", 64'(ifc.result_o), 64'(held));
        end

        adv_i = 1'b1;
        drive(d0, 1'b1, 1'b0);
        @(negedge clk);
        drive(d0, 1'b0, 1'b0);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        repeat (4) begin
            chk("flush_rdy", 64'(ifc.rdy_o), 64'd0);
            @(negedge clk);
        end

        drive(d0, 1'b1, 1'b1);
        @(negedge clk);
        drive(d0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_reset_rdy", 64'(ifc.rdy_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_rdy", 64'(ifc.rdy_o), 64'd0);
        chk("async_reset_outputs", 64'(dut_resp()), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
